// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// One radix-2 step per cycle; divide-by-zero and signed overflow finish immediately.
module ex_muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            stall_ex,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic [2:0]          f3_q, f3_d;
   logic                neg_q, neg_d;
   logic                aneg_q, aneg_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic                div_zero, div_ovf;
   logic [XLEN:0]       msum;
   logic [2*XLEN-1:0]   mul_nxt, div_nxt;
   logic [XLEN:0]       shifted;
   logic                ge;
   logic [XLEN-1:0]     dsub;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quov, remv, fin_res;

   assign a_sgn = (funct3 == 3'b001) | (funct3 == 3'b010) |
                  (funct3 == 3'b100) | (funct3 == 3'b110);
   assign b_sgn = (funct3 == 3'b001) | (funct3 == 3'b100) |
                  (funct3 == 3'b110);
   assign a_neg = a_sgn & op_a[XLEN-1];
   assign b_neg = b_sgn & op_b[XLEN-1];
   assign a_mag = a_neg ? -op_a : op_a;
   assign b_mag = b_neg ? -op_b : op_b;

   assign div_zero = funct3[2] & (op_b == '0);
   assign div_ovf  = funct3[2] & ~funct3[0] &
                     (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);

   // Multiply: acc = {partial product, remaining multiplier bits}
   assign msum    = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    {1'b0, b_q & {XLEN{acc_q[0]}}};
   assign mul_nxt = {msum, acc_q[XLEN-1:1]};

   // Divide: acc = {partial remainder, dividend shifting into quotient}
   assign shifted = acc_q[2*XLEN-1:XLEN-1];
   assign ge      = shifted >= {1'b0, b_q};
   assign dsub    = shifted[XLEN-1:0] - b_q;
   assign div_nxt = {ge ? dsub : shifted[XLEN-1:0],
                     acc_q[XLEN-2:0], ge};

   assign prod = neg_q ? -acc_q : acc_q;
   assign quov = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign remv = aneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      fin_res = quov;
      if (!f3_q[2]) begin
         fin_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                        : prod[2*XLEN-1:XLEN];
      end else if (f3_q[1]) begin
         fin_res = remv;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      b_d      = b_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      aneg_d   = aneg_q;
      result_d = result_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               f3_d   = funct3;
               neg_d  = a_neg ^ b_neg;
               aneg_d = a_neg;
               acc_d  = {{XLEN{1'b0}}, a_mag};
               b_d    = b_mag;
               cnt_d  = 6'd0;
               if (div_zero) begin
                  result_d = funct3[1] ? op_a : '1;
                  state_d  = S_DONE;
               end else if (div_ovf) begin
                  result_d = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                  state_d  = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            cnt_d = cnt_q + 6'd1;
            acc_d = f3_q[2] ? div_nxt : mul_nxt;
            if (cnt_q == 6'd31) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            result_d = fin_res;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A squashed op must leave the architectural result untouched
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         aneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         aneg_q   <= aneg_d;
         result_q <= result_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE) & ~flush & ~rst;
   assign stall_ex = ~rst & ~flush &
                     (((state_q == S_IDLE) & start) |
                      (state_q == S_CALC) | (state_q == S_FIN));
   assign result   = result_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: directed RV32M vectors,
// latency, stall window, flush, reset and ignored-start scenarios.
module tb_ex_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        stall_ex;
   logic        busy;
   logic        done;
   logic [31:0] result;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      string       nm;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;

   ex_muldiv_sequencer #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .funct3   (funct3),
      .op_a     (op_a),
      .op_b     (op_b),
      .flush    (flush),
      .stall_ex (stall_ex),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected response
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: got result %h expected no done (cycle %0d)",
                     result, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.nm, "_result"}, result, e.res);
            chk({e.nm, "_cycle"}, cyc, e.cyc);
         end
      end
   end

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int lat, input int inj, input string nm);
      int t0;
      int stalls;
      bit seen;
      @(posedge clk);
      #1;
      t0 = cyc;
      sb_q.push_back('{exp, t0 + lat, nm});
      funct3 = f3;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      stalls = 0;
      seen   = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            chk({nm, "_stall_at_done"}, {31'b0, stall_ex}, 32'd0);
         end else if (stall_ex) begin
            stalls++;
         end
         if (cyc != t0) begin
            start = (inj != 0) && (cyc == t0 + inj);
            if (start) begin
               funct3 = 3'b011;
               op_a   = 32'h1234_5678;
               op_b   = 32'h0000_0100;
            end
         end
      end
      start = 1'b0;
      if (!seen) begin
         checks++;
         fails++;
         $display("FAIL %s_timeout: got no done expected done by cycle %0d",
                  nm, t0 + lat);
      end else begin
         chk({nm, "_stall_cycles"}, stalls, lat);
      end
   endtask

   initial begin
      int t0;
      rst    = 1'b1;
      start  = 1'b1;
      funct3 = 3'b000;
      op_a   = 32'd3;
      op_b   = 32'd4;
      flush  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_stall", {31'b0, stall_ex}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0, "mul_7x-3");
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0, "mulhu_max");
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0, "mulhsu_max");
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0, "mulh_min");
      run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0, "mulh_neg");
      run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 0, "div_-7/2");
      run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0, "rem_-7/2");
      run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 0, "divu_100/7");
      run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, 0, "remu_100/7");
      run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0, "div_7/-2");
      run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0, "rem_7/-2");
      run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu_by0");
      run_op(3'b111, 32'd9, 32'd0, 32'd9, 1, 0, "remu_by0");
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
      run_op(3'b000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 34, 5, "mul_ignore_start");

      // Flush a divide mid-calculation
      @(posedge clk);
      #1;
      t0     = cyc;
      funct3 = 3'b100;
      op_a   = 32'd1000;
      op_b   = 32'd3;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      while (cyc < t0 + 10) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", {31'b0, stall_ex}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {31'b0, busy}, 32'd0);
      chk("flush_result_held", result, 32'h0123_4500);
      run_op(3'b000, 32'd12, 32'd11, 32'd132, 34, 0, "mul_after_flush");

      // Start and flush together in IDLE: nothing accepted
      @(posedge clk);
      #1;
      funct3 = 3'b000;
      op_a   = 32'd2;
      op_b   = 32'd2;
      start  = 1'b1;
      flush  = 1'b1;
      @(negedge clk);
      chk("start_flush_stall", {31'b0, stall_ex}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("start_flush_busy", {31'b0, busy}, 32'd0);

      // Reset in the middle of a multiply
      @(posedge clk);
      #1;
      t0     = cyc;
      funct3 = 3'b000;
      op_a   = 32'd6;
      op_b   = 32'd9;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      while (cyc < t0 + 20) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_stall", {31'b0, stall_ex}, 32'd0);
      chk("midrst_result", result, 32'd0);
      repeat (40) @(negedge clk);
      run_op(3'b000, 32'd3, 32'd5, 32'd15, 34, 0, "mul_after_rst");

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_sequencer.md
EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  valid M-extension op present in execute stage.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  32  rs1 operand (forwarded regfilea).
REQ-007 op_b  input  32  rs2 operand (forwarded regfileb).
REQ-008 flush  input  1  squash in-flight op (taken branch/jump redirect).
REQ-009 stall_ex  output  1  hold IF/ID/EX pipeline registers.
REQ-010 busy  output  1  sequencer not in IDLE.
REQ-011 done  output  1  result valid this cycle, one-cycle pulse.
REQ-012 result  output  32  final product/quotient/remainder.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FIN, DONE; encoding is free.
REQ-014 IDLE: start=1 and flush=0 -> latch funct3, op_a, op_b, clear the 6-bit iteration counter, go to CALC; special case (REQ-020/021) -> go directly to DONE.
REQ-015 CALC: one radix-2 step per cycle (shift-add multiply on a 64-bit accumulator; restoring divide on a 33-bit partial remainder using operand magnitudes); counter increments; after 32 steps (counter==31) -> FIN.
REQ-016 FIN: apply sign correction (negate quotient if operand signs differ for DIV; remainder takes dividend's sign for REM), select upper/lower product half per funct3, register result -> DONE.
REQ-017 DONE: done=1, stall_ex=0, result held -> IDLE next cycle.
REQ-018 Latency: start sampled at edge T -> CALC T+1..T+32, FIN T+33, done=1 during cycle T+34.
REQ-019 stall_ex SHALL be (IDLE & start & ~flush) | CALC | FIN, combinational, so the issuing instruction is held from its first EX cycle.
REQ-020 Divide by zero: DIV/DIVU result 0xFFFFFFFF, REM/REMU result op_a; done at T+1.
REQ-021 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV result 0x80000000, REM result 0; done at T+1.
REQ-022 MULH signed x signed, MULHSU signed op_a x unsigned op_b, MULHU unsigned x unsigned; MUL returns low 32 bits; all modulo 2^64.
REQ-023 start while busy SHALL be ignored; latched operands are unaffected.
REQ-024 flush in any state: next state IDLE, done SHALL NOT assert for the squashed op, stall_ex=0 in that cycle; flush and start together in IDLE -> no op accepted.
REQ-025 result SHALL hold its last value outside DONE; only done qualifies it.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 rst=1 at an edge: state IDLE, counter 0, accumulators 0, result 0x00000000; outputs stall_ex=0 (rst also masks the combinational term), busy=0, done=0.
REQ-028 rst mid-operation SHALL abandon the op with no done pulse; rst has priority over flush and start.

Verification
REQ-029 MUL 7 x -3 (0x00000007, 0xFFFFFFFD), start at T -> stall_ex high T..T+33, done at T+34, result 0xFFFFFFEB.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE at T+34; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each done at T+34.
REQ-032 DIVU 5/0 -> done at T+1, result 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> done at T+1, result 0.
REQ-033 Start DIV, assert flush at T+10 -> busy=0 from T+11, no done pulse; new MUL started at T+12 completes at T+46 correctly.
REQ-034 Start MUL, rst at T+20 -> all outputs 0 at T+21; second start during CALC -> ignored, original result unchanged.
